// File: rtl/ra_pq_ins_if.sv
// ra_pq_ins_if: command/head/status bundle between a priority-queue user (master) and ra_pq_ins (slave)
//   enq/deq/flush, kvi_key/kvi_val : commands and key/value to insert
//   kvo_key/kvo_val                : head entry (0 when empty)
//   empty/full/count/busy/ovf/udf  : occupancy and sticky error status
interface ra_pq_ins_if #(
    parameter int KEY_W    = 16,
    parameter int VAL_W    = 16,
    parameter int CAPACITY = 8
) ();
    localparam int CW = $clog2(CAPACITY + 1);
    logic             enq;
    logic             deq;
    logic             flush;
    logic [KEY_W-1:0] kvi_key;
    logic [VAL_W-1:0] kvi_val;
    logic [KEY_W-1:0] kvo_key;
    logic [VAL_W-1:0] kvo_val;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             busy;
    logic             ovf;
    logic             udf;
    modport master (output enq, deq, flush, kvi_key, kvi_val,
                    input  kvo_key, kvo_val, empty, full, count, busy, ovf, udf);
    modport slave  (input  enq, deq, flush, kvi_key, kvi_val,
                    output kvo_key, kvo_val, empty, full, count, busy, ovf, udf);
endinterface

// File: rtl/ra_pq_ins.sv
// ra_pq_ins: single-cycle register-array priority queue kept fully sorted (slot 0 = best)
//   clk, rst : clock and synchronous active-high reset
//   bus      : ra_pq_ins_if.slave (commands in, head entry and status out)
module ra_pq_ins #(
    parameter int KEY_W     = 16,
    parameter int VAL_W     = 16,
    parameter int CAPACITY  = 8,
    parameter int MAX_MODE  = 0,
    parameter int OVF_EVICT = 0
) (
    input  logic        clk,
    input  logic        rst,
    ra_pq_ins_if.slave  bus
);
    localparam int CW = $clog2(CAPACITY + 1);

    typedef struct packed {
        logic             v;
        logic [KEY_W-1:0] k;
        logic [VAL_W-1:0] d;
    } slot_t;

    slot_t         slot_q [CAPACITY];
    slot_t         slot_d [CAPACITY];
    slot_t         sh     [CAPACITY];
    slot_t         base   [CAPACITY];
    slot_t         ins    [CAPACITY];
    slot_t         kvi;
    logic [CAPACITY-1:0] ge;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          empty, full, pop, do_ins, inc, dec;

    function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        return (MAX_MODE != 0) ? (a > b) : (a < b);
    endfunction

    assign empty  = count_q == '0;
    assign full   = count_q == CW'(CAPACITY);
    assign pop    = bus.deq && !empty;
    assign kvi    = {1'b1, bus.kvi_key, bus.kvi_val};
    // a full queue only accepts via replace, or via eviction when kvi beats the worst slot
    assign do_ins = bus.enq && (!full || bus.deq ||
                    (OVF_EVICT != 0 && better(bus.kvi_key, slot_q[CAPACITY-1].k)));
    assign inc    = bus.enq && (bus.deq ? empty : !full);
    assign dec    = bus.deq && !bus.enq && !empty;

    always_comb begin
        for (int i = 0; i < CAPACITY - 1; i++) sh[i] = slot_q[i+1];
        sh[CAPACITY-1] = '0;
        for (int i = 0; i < CAPACITY; i++) base[i] = pop ? sh[i] : slot_q[i];
        // ge marks slots that stay ahead of kvi: valid and not worse than it (ties keep FIFO order)
        for (int i = 0; i < CAPACITY; i++) ge[i] = base[i].v && !better(bus.kvi_key, base[i].k);
        ins[0] = ge[0] ? base[0] : kvi;
        for (int i = 1; i < CAPACITY; i++) ins[i] = ge[i] ? base[i] : ge[i-1] ? kvi : base[i-1];
        for (int i = 0; i < CAPACITY; i++) slot_d[i] = bus.flush ? '0 : do_ins ? ins[i] : base[i];
        count_d = bus.flush ? '0 : count_q + CW'(inc) - CW'(dec);
        ovf_d   = !bus.flush && (ovf_q || (bus.enq && !bus.deq && full));
        udf_d   = !bus.flush && (udf_q || (bus.deq && empty));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CAPACITY; i++) slot_q[i] <= rst ? '0 : slot_d[i];
        count_q <= rst ? '0 : count_d;
        ovf_q   <= rst ? 1'b0 : ovf_d;
        udf_q   <= rst ? 1'b0 : udf_d;
    end

    assign bus.kvo_key = slot_q[0].k;
    assign bus.kvo_val = slot_q[0].d;
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.count   = count_q;
    assign bus.busy    = 1'b0;
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;
endmodule
